// File: rtl/reg_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file: two combinational read ports, one synchronous
// write port, per-register "written since reset" flags and optional write-through forwarding.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITEENABLE,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  OUT1VALID,
  output logic                  OUT2VALID
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [DATA_WIDTH-1:0] regs_d [Depth];
  logic [Depth-1:0]      valid_q;
  logic [Depth-1:0]      valid_d;
  logic                  wr_en;
  logic                  fwd1;
  logic                  fwd2;

  // A write coinciding with reset is dropped; reset wins.
  assign wr_en = WRITEENABLE && !RESET;

  always_comb begin
    regs_d  = regs_q;
    valid_d = valid_q;
    if (wr_en) begin
      regs_d[INADDRESS]  = IN;
      valid_d[INADDRESS] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      regs_q  <= regs_d;
      valid_q <= valid_d;
    end
  end

  assign fwd1 = BYPASS && wr_en && (INADDRESS == OUT1ADDRESS);
  assign fwd2 = BYPASS && wr_en && (INADDRESS == OUT2ADDRESS);

  always_comb begin
    OUT1      = regs_q[OUT1ADDRESS];
    OUT2      = regs_q[OUT2ADDRESS];
    OUT1VALID = valid_q[OUT1ADDRESS];
    OUT2VALID = valid_q[OUT2ADDRESS];
    if (fwd1) begin
      OUT1      = IN;
      OUT1VALID = 1'b1;
    end
    if (fwd2) begin
      OUT2      = IN;
      OUT2VALID = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file; a forwarding and a non-forwarding instance share all inputs.
module tb_reg_file;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [2:0] wa;
  logic       we;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic [7:0] b_out1, b_out2, n_out1, n_out2;
  logic       b_v1, b_v2, n_v1, n_v2;

  int n_vec;
  int n_fail;
  logic [7:0] exp_q [8];

  reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b1)) u_dut_byp (
    .CLK(clk), .RESET(rst), .IN(din), .INADDRESS(wa), .WRITEENABLE(we),
    .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2), .OUT1(b_out1), .OUT2(b_out2),
    .OUT1VALID(b_v1), .OUT2VALID(b_v2)
  );

  reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b0)) u_dut_nb (
    .CLK(clk), .RESET(rst), .IN(din), .INADDRESS(wa), .WRITEENABLE(we),
    .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2), .OUT1(n_out1), .OUT2(n_out2),
    .OUT1VALID(n_v1), .OUT2VALID(n_v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wa  = a;
    din = d;
    we  = 1'b1;
    tick();
    we  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a1, input logic [2:0] a2);
    ra1 = a1;
    ra2 = a2;
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst = 1'b0; din = 8'h00; wa = 3'd0; we = 1'b0; ra1 = 3'd0; ra2 = 3'd0;

    // Reset then sweep all addresses.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(i[2:0], 3'(7 - i));
      check($sformatf("rst_b_out1_%0d", i), b_out1, 8'h00);
      check($sformatf("rst_b_out2_%0d", i), b_out2, 8'h00);
      check($sformatf("rst_b_v1_%0d", i), b_v1, 1'b0);
      check($sformatf("rst_b_v2_%0d", i), b_v2, 1'b0);
      check($sformatf("rst_n_out1_%0d", i), n_out1, 8'h00);
      check($sformatf("rst_n_v2_%0d", i), n_v2, 1'b0);
    end

    // Operand load, then ALU OR result 0x0F|0xF0 = 0xFF into r3.
    wr(3'd1, 8'h0F);
    wr(3'd2, 8'hF0);
    rd(3'd1, 3'd2);
    check("load_out1", b_out1, 8'h0F);
    check("load_out2", b_out2, 8'hF0);
    check("load_v1", b_v1, 1'b1);
    check("load_v2", b_v2, 1'b1);
    wr(3'd3, 8'hFF);
    rd(3'd3, 3'd1);
    check("alu_r3", b_out1, 8'hFF);
    check("alu_r1_hold", b_out2, 8'h0F);
    rd(3'd2, 3'd3);
    check("alu_r2_hold", n_out1, 8'hF0);
    check("alu_r3_nb", n_out2, 8'hFF);

    // Forwarding into a not-yet-written register: only the bypass instance flags valid.
    rd(3'd4, 3'd0);
    wa = 3'd4; din = 8'h11; we = 1'b1;
    #1;
    check("fwd_unwr_b_out1", b_out1, 8'h11);
    check("fwd_unwr_b_v1", b_v1, 1'b1);
    check("fwd_unwr_n_out1", n_out1, 8'h00);
    check("fwd_unwr_n_v1", n_v1, 1'b0);
    check("fwd_other_port", b_v2, 1'b0);
    tick();
    we = 1'b0;
    // r4 = 0x11, now overwrite with 0xAA.
    wa = 3'd4; din = 8'hAA; we = 1'b1;
    #1;
    check("fwd_b_pre", b_out1, 8'hAA);
    check("fwd_n_pre", n_out1, 8'h11);
    tick();
    we = 1'b0;
    #1;
    check("fwd_b_post", b_out1, 8'hAA);
    check("fwd_n_post", n_out1, 8'hAA);
    check("fwd_n_post_v", n_v1, 1'b1);

    // Write/reset collision.
    wr(3'd5, 8'h3C);
    rd(3'd5, 3'd1);
    rst = 1'b1; wa = 3'd5; din = 8'h77; we = 1'b1;
    #1;
    check("coll_b_pre", b_out1, 8'h3C);
    check("coll_n_pre", n_out1, 8'h3C);
    check("coll_b_pre_v", b_v1, 1'b1);
    check("coll_r1_pre", b_out2, 8'h0F);
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    check("coll_b_post", b_out1, 8'h00);
    check("coll_b_post_v", b_v1, 1'b0);
    check("coll_n_post", n_out1, 8'h00);
    check("coll_r1_cleared", b_out2, 8'h00);
    check("coll_r1_cleared_v", b_v2, 1'b0);

    // Isolation: fill r0..r7, then overwrite r6 with zero.
    for (int i = 0; i < 8; i++) begin
      exp_q[i] = 8'h80 | 8'(i);
      wr(i[2:0], exp_q[i]);
    end
    wr(3'd6, 8'h00);
    exp_q[6] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rd(i[2:0], i[2:0]);
      check($sformatf("iso_b_out1_%0d", i), b_out1, exp_q[i]);
      check($sformatf("iso_n_out2_%0d", i), n_out2, exp_q[i]);
      check($sformatf("iso_b_v1_%0d", i), b_v1, 1'b1);
    end

    // Both ports on r7, plain and with a concurrent write.
    wr(3'd7, 8'h5A);
    rd(3'd7, 3'd7);
    check("same_out1", b_out1, 8'h5A);
    check("same_out2", b_out2, 8'h5A);
    wa = 3'd7; din = 8'hC3; we = 1'b1;
    #1;
    check("same_fwd_b1", b_out1, 8'hC3);
    check("same_fwd_b2", b_out2, 8'hC3);
    check("same_fwd_n1", n_out1, 8'h5A);
    check("same_fwd_n2", n_out2, 8'h5A);
    tick();
    we = 1'b0;
    #1;
    check("same_post_n1", n_out1, 8'hC3);
    check("same_post_n2", n_out2, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 8 x 8-bit register file; the operand source and result sink for `alu` in the single-cycle datapath.
- Two combinational read ports drive the ALU's `DATA1`/`DATA2`; one synchronous write port captures the ALU's `RESULT`.
- Per-register valid bits flag registers not yet written since reset, so the control/verification side can detect reads of uninitialised operands.

Parameters:
- `DATA_WIDTH`, 8, register width; matches ALU operand width.
- `ADDR_WIDTH`, 3, address width; depth = 2**`ADDR_WIDTH` = 8 registers.
- `BYPASS`, 1, 1 = write-through forwarding of a same-cycle write to the read ports; 0 = reads return the pre-edge value.

Ports:
- `CLK`  input  1  clock; all state updates on rising edge.
- `RESET`  input  1  synchronous, active-high reset.
- `IN`  input  `DATA_WIDTH`  write data (ALU `RESULT`).
- `INADDRESS`  input  `ADDR_WIDTH`  write register index.
- `WRITEENABLE`  input  1  write strobe, sampled at rising edge.
- `OUT1ADDRESS`  input  `ADDR_WIDTH`  read port 1 index.
- `OUT2ADDRESS`  input  `ADDR_WIDTH`  read port 2 index.
- `OUT1`  output  `DATA_WIDTH`  read port 1 data (to ALU `DATA1`).
- `OUT2`  output  `DATA_WIDTH`  read port 2 data (to ALU `DATA2`).
- `OUT1VALID`  output  1  register at `OUT1ADDRESS` has been written since reset.
- `OUT2VALID`  output  1  register at `OUT2ADDRESS` has been written since reset.

Behaviour:
- Reset:
  - Synchronous, active-high. At a rising edge with `RESET`=1, all 8 registers clear to 0x00 and all valid bits clear to 0.
  - A write in the same cycle as `RESET` is discarded, whatever `WRITEENABLE` is.
  - After the reset edge: `OUT1`=`OUT2`=0x00, `OUT1VALID`=`OUT2VALID`=0 for any address.
  - Reset asserted mid-sequence takes effect at the next edge only; between `RESET` rising and that edge, outputs still reflect the old contents.
- Write:
  - At a rising edge with `RESET`=0 and `WRITEENABLE`=1: `reg[INADDRESS]` <= `IN` and `valid[INADDRESS]` <= 1.
  - Single-cycle latency. One write per cycle.
  - Exactly one register is updated per write; all others hold.
  - `WRITEENABLE`=0: no state change.
- Read:
  - Purely combinational from the address inputs and state; zero-cycle latency. No clock involvement.
  - `OUTnVALID` = `valid[OUTnADDRESS]`.
  - Both ports may address the same register; both return identical data.
  - Register 0 is an ordinary writable register; there is no hardwired zero.
- Bypass, `BYPASS`=1:
  - Condition: `WRITEENABLE`=1, `RESET`=0 and `INADDRESS`==`OUTnADDRESS`.
  - Then `OUTn`=`IN` and `OUTnVALID`=1 in the same cycle, before the edge. Applies to each port independently.
  - When `RESET`=1, no bypass: outputs show the stored contents.
- Bypass, `BYPASS`=0: read of the address being written returns the old value until the edge; the new value is visible from the edge onward.
- Widths: no arithmetic; data stored and returned bit-exact. Addresses are full-range, so there is no out-of-range case.
- State: no FSM. State is 8 data registers plus an 8-bit valid vector; no other storage.
- Unknowns: X/Z on `WRITEENABLE` is not a legal input; the bench does not drive it.

Test Plan:
- Reset then read: assert `RESET` for 1 edge, sweep `OUT1ADDRESS`/`OUT2ADDRESS` 0..7 -> `OUT1`=`OUT2`=0x00, both valids 0 at every address.
- Operand load: write 0x0F to r1, then 0xF0 to r2; set `OUT1ADDRESS`=1, `OUT2ADDRESS`=2 -> `OUT1`=0x0F, `OUT2`=0xF0, both valids 1. Through the ALU with `SELECT`=001, write `RESULT` 0xFF to r3 -> read r3 = 0xFF; r1/r2 unchanged.
- Same-cycle forwarding (`BYPASS`=1): r4=0x11; drive `WRITEENABLE`=1, `INADDRESS`=4, `IN`=0xAA, `OUT1ADDRESS`=4 -> `OUT1`=0xAA before the edge. With `BYPASS`=0, the same stimulus gives `OUT1`=0x11 before the edge and 0xAA after.
- Write/reset collision: r5=0x3C; at one edge drive `RESET`=1, `WRITEENABLE`=1, `INADDRESS`=5, `IN`=0x77 -> r5=0x00 and valid[5]=0 after the edge. No bypass: `OUT1`=0x3C before the edge.
- Isolation: write each r0..r7 with 0x80|index, then overwrite r6 with 0x00 -> all other registers retain their values; valid[6] stays 1.
- Both ports on the same address: `OUT1ADDRESS`=`OUT2ADDRESS`=7 with r7=0x5A -> `OUT1`=`OUT2`=0x5A. With a concurrent write of 0xC3 to r7 and `BYPASS`=1 -> both read 0xC3.
